// File: rtl/vip_stream_gate_ctrl.sv
// vip_stream_gate_ctrl: run/stop gate for an Avalon-ST video stream.
// Packets are started and stopped only on boundaries.
// Discarded packets are swallowed with din_ready held high.
// Video packet counters and an end-of-frame interrupt are readable over a small Avalon-MM slave.
// Optional feature macro: FRAME_LIMIT_EN. It adds a frame_limit register at address 5.
// That register automatically clears go once pass_cnt reaches the limit.
module vip_stream_gate_ctrl #(
  parameter int   DATA_WIDTH = 8,
  parameter int   CNT_WIDTH  = 16,
  parameter logic GO_RESET   = 1'b1
) (
  input  logic                  vst_clk,
  input  logic                  vst_rst_n,
  input  logic [2:0]            av_address,
  input  logic                  av_read,
  input  logic                  av_write,
  input  logic [31:0]           av_writedata,
  output logic [31:0]           av_readdata,
  output logic                  av_readdatavalid,
  output logic                  av_waitrequest,
  output logic                  av_irq,
  input  logic [DATA_WIDTH-1:0] din_data,
  input  logic                  din_valid,
  input  logic                  din_startofpacket,
  input  logic                  din_endofpacket,
  output logic                  din_ready,
  output logic [DATA_WIDTH-1:0] dout_data,
  output logic                  dout_valid,
  output logic                  dout_startofpacket,
  output logic                  dout_endofpacket,
  input  logic                  dout_ready
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PASS = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]           state_r;
  logic [1:0]           state_nxt_s;
  logic                 go_r;
  logic                 irqen_r;
  logic                 irq_r;
  logic                 is_video_r;
  logic [CNT_WIDTH-1:0] pass_cnt_r;
  logic [CNT_WIDTH-1:0] drop_cnt_r;

  logic        fwd_s;
  logic        accept_s;
  logic        sop_start_s;
  logic        sop_video_s;
  logic        pkt_video_s;
  logic        pkt_eop_s;
  logic        pass_inc_s;
  logic        drop_inc_s;
  logic        in_packet_s;
  logic        limit_hit_s;
  logic        wr_ctrl_s;
  logic        wr_irq_clr_s;
  logic        wr_cnt_clr_s;
  logic [31:0] limit_rd_s;
  logic [31:0] rd_mux_s;
  logic        unused_s;

  // The write data word is only partially decoded.
  assign unused_s = &{1'b0, av_writedata};

  assign wr_ctrl_s    = av_write & (av_address == 3'd0);
  assign wr_irq_clr_s = av_write & (av_address == 3'd2);
  assign wr_cnt_clr_s = av_write & (av_address == 3'd4);

  assign av_waitrequest = 1'b0;
  assign av_irq         = irqen_r & irq_r;
  assign in_packet_s    = (state_r != ST_IDLE);

  // Forward/discard decision for the beat currently on din.
  // In IDLE, only an SOP beat with go set opens a forwarded packet.
  always_comb begin
    fwd_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (din_startofpacket && go_r) begin
          fwd_s = 1'b1;
        end else begin
          fwd_s = 1'b0;
        end
      end
      ST_PASS: fwd_s = 1'b1;
      ST_DROP: fwd_s = 1'b0;
      default: fwd_s = 1'b0;
    endcase
  end

  // Zero-latency datapath.
  // Both handshakes are forced low while reset is asserted.
  assign dout_data          = din_data;
  assign dout_startofpacket = din_startofpacket;
  assign dout_endofpacket   = din_endofpacket;
  assign dout_valid         = vst_rst_n & fwd_s & din_valid;
  assign din_ready          = vst_rst_n & (fwd_s ? dout_ready : 1'b1);

  assign accept_s    = din_valid & din_ready;
  assign sop_start_s = (state_r == ST_IDLE) & din_startofpacket & accept_s;
  assign sop_video_s = (din_data[3:0] == 4'h0);
  assign pkt_video_s = sop_start_s ? sop_video_s : is_video_r;
  assign pkt_eop_s   = accept_s & din_endofpacket & (in_packet_s | sop_start_s);
  assign pass_inc_s  = pkt_eop_s & pkt_video_s & fwd_s;
  assign drop_inc_s  = pkt_eop_s & pkt_video_s & ~fwd_s;

  // Packet state machine. Stray non-SOP beats in IDLE leave it in IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (sop_start_s && !din_endofpacket) begin
          state_nxt_s = go_r ? ST_PASS : ST_DROP;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_PASS, ST_DROP: begin
        if (accept_s && din_endofpacket) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register and packet type latched at SOP acceptance.
  always_ff @(posedge vst_clk or negedge vst_rst_n) begin
    if (!vst_rst_n) begin
      state_r    <= ST_IDLE;
      is_video_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (sop_start_s) begin
        is_video_r <= sop_video_s;
      end else begin
        is_video_r <= is_video_r;
      end
    end
  end

`ifdef FRAME_LIMIT_EN
  logic [CNT_WIDTH-1:0] frame_limit_r;

  assign limit_hit_s = pass_inc_s & (frame_limit_r != CNT_ZERO) &
                       ((pass_cnt_r + CNT_ONE) == frame_limit_r);
  assign limit_rd_s  = 32'(frame_limit_r);

  // Frame limit register (0 = unlimited).
  always_ff @(posedge vst_clk or negedge vst_rst_n) begin
    if (!vst_rst_n) begin
      frame_limit_r <= CNT_ZERO;
    end else if (av_write && (av_address == 3'd5)) begin
      frame_limit_r <= av_writedata[CNT_WIDTH-1:0];
    end else begin
      frame_limit_r <= frame_limit_r;
    end
  end
`else
  assign limit_hit_s = 1'b0;
  assign limit_rd_s  = 32'h0000_0000;
`endif

  // Control register. Hitting the frame limit overrides a software write of go.
  always_ff @(posedge vst_clk or negedge vst_rst_n) begin
    if (!vst_rst_n) begin
      go_r    <= GO_RESET;
      irqen_r <= 1'b0;
    end else begin
      if (limit_hit_s) begin
        go_r <= 1'b0;
      end else if (wr_ctrl_s) begin
        go_r <= av_writedata[0];
      end else begin
        go_r <= go_r;
      end
      if (wr_ctrl_s) begin
        irqen_r <= av_writedata[1];
      end else begin
        irqen_r <= irqen_r;
      end
    end
  end

  // End-of-frame interrupt flag. A set in the same cycle as a clear wins.
  always_ff @(posedge vst_clk or negedge vst_rst_n) begin
    if (!vst_rst_n) begin
      irq_r <= 1'b0;
    end else if (pass_inc_s) begin
      irq_r <= 1'b1;
    end else if (wr_irq_clr_s) begin
      irq_r <= 1'b0;
    end else begin
      irq_r <= irq_r;
    end
  end

  // Frame counters, wrapping. A clear in the same cycle as an increment wins.
  always_ff @(posedge vst_clk or negedge vst_rst_n) begin
    if (!vst_rst_n) begin
      pass_cnt_r <= CNT_ZERO;
      drop_cnt_r <= CNT_ZERO;
    end else if (wr_cnt_clr_s) begin
      pass_cnt_r <= CNT_ZERO;
      drop_cnt_r <= CNT_ZERO;
    end else begin
      pass_cnt_r <= pass_inc_s ? (pass_cnt_r + CNT_ONE) : pass_cnt_r;
      drop_cnt_r <= drop_inc_s ? (drop_cnt_r + CNT_ONE) : drop_cnt_r;
    end
  end

  // Read data multiplexer.
  always_comb begin
    rd_mux_s = 32'h0000_0000;
    case (av_address)
      3'd0:    rd_mux_s = {30'h0000_0000, irqen_r, go_r};
      3'd1:    rd_mux_s = {29'h0000_0000, in_packet_s, state_r};
      3'd2:    rd_mux_s = {31'h0000_0000, av_irq};
      3'd3:    rd_mux_s = 32'(pass_cnt_r);
      3'd4:    rd_mux_s = 32'(drop_cnt_r);
      3'd5:    rd_mux_s = limit_rd_s;
      default: rd_mux_s = 32'h0000_0000;
    endcase
  end

  // Registered read port: data and a one-cycle valid pulse in the cycle after av_read.
  always_ff @(posedge vst_clk or negedge vst_rst_n) begin
    if (!vst_rst_n) begin
      av_readdata      <= 32'h0000_0000;
      av_readdatavalid <= 1'b0;
    end else begin
      av_readdatavalid <= av_read;
      if (av_read) begin
        av_readdata <= rd_mux_s;
      end else begin
        av_readdata <= av_readdata;
      end
    end
  end

endmodule

// File: doc/vip_stream_gate_ctrl.md
Name: vip_stream_gate_ctrl

Overview:
Run/stop controller for an Avalon-ST video stream, placed between the raw-to-VIP bridge output and downstream VIP cores. Starts and stops the stream only on packet boundaries, so downstream never sees a truncated packet. It discards packets while stopped, counts passed and dropped frames, and raises an end-of-frame interrupt. Software controls it through a small Avalon-MM slave on the same clock.

Parameters:
DATA_WIDTH, 8, width of din_data/dout_data; must be >= 4 because bits [3:0] of the SOP beat carry the VIP packet type.
CNT_WIDTH, 16, width of the passed-frame and dropped-frame counters.
GO_RESET, 1'b1, reset value of the go bit.

Ports:
vst_clk  in  1  clock for all logic.
vst_rst_n  in  1  asynchronous active-low reset.
av_address  in  3  register word address.
av_read  in  1  read strobe.
av_write  in  1  write strobe.
av_writedata  in  32  write data.
av_readdata  out  32  read data, registered.
av_readdatavalid  out  1  read data valid.
av_waitrequest  out  1  tied to 0.
av_irq  out  1  interrupt, equal to irqen & irq_reg.
din_data  in  DATA_WIDTH  input stream data.
din_valid  in  1  input stream valid.
din_startofpacket  in  1  input SOP.
din_endofpacket  in  1  input EOP.
din_ready  out  1  input ready.
dout_data  out  DATA_WIDTH  output stream data, equal to din_data.
dout_valid  out  1  output stream valid.
dout_startofpacket  out  1  output SOP.
dout_endofpacket  out  1  output EOP.
dout_ready  in  1  output ready.

Behaviour:
- Reset values: av_readdata=0, av_readdatavalid=0, irq_reg=0, irqen=0, go=GO_RESET, both counters=0, state=IDLE. While reset is asserted, dout_valid=0 and din_ready=0. A reset mid-packet abandons that packet; the next packet starts clean.
- The datapath is combinational with zero latency. A beat is accepted when din_valid & din_ready.
- State machine: IDLE (between packets), PASS (inside a forwarded packet), DROP (inside a discarded packet).
- IDLE, beat with SOP:
  - go=1: forward the beat (dout_valid=din_valid, din_ready=dout_ready). On acceptance go to PASS, or stay in IDLE if the beat also has EOP.
  - go=0: discard the beat (dout_valid=0, din_ready=1). On acceptance go to DROP, or stay in IDLE if the beat also has EOP.
- IDLE, beat without SOP: stray beat. Discard it with din_ready=1 and stay in IDLE; it is not counted.
- PASS: forward every beat. The accepted EOP beat returns the machine to IDLE. Clearing go mid-packet does not cut the packet.
- DROP: discard every beat with din_ready=1. The accepted EOP beat returns the machine to IDLE. Setting go mid-packet takes effect at the next SOP.
- An SOP received in PASS or DROP is treated as a data beat, with no restart.
- Video packet: the SOP beat has din_data[3:0]==4'h0; the type is latched at SOP acceptance. Control packets (any other type) follow the same gating but are not counted.
- At accepted EOP of a video packet:
  - forwarded: pass_cnt increments and irq_reg is set;
  - discarded: drop_cnt increments.
  - Both counters wrap at 2^CNT_WIDTH.
- Registers:
  - address 0 RW: [1]=irqen, [0]=go.
  - address 1 RO: [2]=in_packet, [1:0]=state (IDLE=0, PASS=1, DROP=2).
  - address 2: read returns [0]=av_irq; any write clears irq_reg.
  - address 3 RO: pass_cnt.
  - address 4: read returns drop_cnt; any write clears both counters.
  - Other addresses read 0.
- Reads: av_readdata is updated and av_readdatavalid pulses for one cycle, both in the cycle after av_read.
- Simultaneous events:
  - irq set and irq clear in the same cycle: set wins.
  - counter increment and counter clear in the same cycle: the counter becomes 0.
  - A go write takes effect on the SOP decision in the following cycle.

Optional Feature:
FRAME_LIMIT_EN. When defined, address 5 RW holds frame_limit (CNT_WIDTH bits, reset 0, 0 means unlimited). When frame_limit is nonzero, go is cleared automatically at the accepted EOP of the video packet that makes pass_cnt equal frame_limit. If a software write to address 0 lands in the same cycle, the auto-clear wins. When the macro is not defined, address 5 reads 0 and go changes only through software writes.

Test Plan:
1. Reset, go=1, send two 720x576 video packets, each preceded by a type-F control packet, with dout_ready=1 -> all beats appear on dout unchanged; pass_cnt=2, drop_cnt=0; irq_reg=1.
2. Write go=0 in the middle of video frame 1 -> frame 1 completes intact; frame 2 is discarded with din_ready=1 and dout_valid=0; drop_cnt=1; address 1 reads DROP while frame 2 is in flight.
3. Write go=1 in the middle of a discarded frame -> the rest of that frame is dropped; the next SOP is forwarded; no partial packet appears on dout.
4. Toggle dout_ready randomly in PASS -> din_ready tracks dout_ready; beat order and count are preserved; no beats are lost.
5. Write irqen=1, then write address 2 in the same cycle as a video EOP -> av_irq stays 1. A later write to address 2 drops av_irq to 0.
6. With FRAME_LIMIT_EN and frame_limit=3, send 5 frames -> pass_cnt=3, drop_cnt=2, and go reads 0 after frame 3.
